// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - RISC-V five-stage control path with load-use stall and branch flush
module pipelined_control_unit #(
    parameter int RA_W        = 5,
    parameter int LOAD_STALL  = 1,
    parameter bit SUPPORT_JAL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      Opcode,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            mem_take,
    output logic            stall,
    output logic            flush,
    output logic            ex_ALUSrc,
    output logic [1:0]      ex_ALUOp,
    output logic [RA_W-1:0] ex_rd,
    output logic            mem_MemRead,
    output logic            mem_MemWrite,
    output logic            mem_Branch,
    output logic            mem_Jump,
    output logic [RA_W-1:0] mem_rd,
    output logic            wb_RegWrite,
    output logic            wb_MemtoReg,
    output logic [RA_W-1:0] wb_rd
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // LOAD_STALL is legal in 1..3, so the reload value always fits two bits
    localparam logic [1:0] CNT_LOAD = 2'(LOAD_STALL - 1);

    logic            d_alusrc, d_memtoreg, d_regwrite, d_memread;
    logic            d_memwrite, d_branch, d_jump;
    logic [1:0]      d_aluop;
    logic [RA_W-1:0] d_rd;
    logic            use_rs1, use_rs2;

    logic            ex_memread, ex_memwrite, ex_branch, ex_jump;
    logic            ex_regwrite, ex_memtoreg;
    logic            mem_regwrite, mem_memtoreg;

    logic [1:0]      cnt;
    logic            cnt_nz;
    logic            haz;
    logic            id_bubble;

    always_comb begin
        d_alusrc   = 1'b0;
        d_memtoreg = 1'b0;
        d_regwrite = 1'b0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_branch   = 1'b0;
        d_jump     = 1'b0;
        d_aluop    = 2'b00;
        d_rd       = '0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        if (id_valid) begin
            case (Opcode)
                OP_R: begin
                    d_regwrite = 1'b1;
                    d_aluop    = 2'b10;
                    d_rd       = id_rd;
                    use_rs1    = 1'b1;
                    use_rs2    = 1'b1;
                end
                OP_LOAD: begin
                    d_alusrc   = 1'b1;
                    d_memtoreg = 1'b1;
                    d_regwrite = 1'b1;
                    d_memread  = 1'b1;
                    d_rd       = id_rd;
                    use_rs1    = 1'b1;
                end
                OP_STORE: begin
                    d_alusrc   = 1'b1;
                    d_memwrite = 1'b1;
                    d_rd       = id_rd;
                    use_rs1    = 1'b1;
                    use_rs2    = 1'b1;
                end
                OP_BRANCH: begin
                    d_branch = 1'b1;
                    d_aluop  = 2'b01;
                    d_rd     = id_rd;
                    use_rs1  = 1'b1;
                    use_rs2  = 1'b1;
                end
                OP_IARITH: begin
                    d_alusrc   = 1'b1;
                    d_regwrite = 1'b1;
                    d_aluop    = 2'b11;
                    d_rd       = id_rd;
                    use_rs1    = 1'b1;
                end
                OP_JAL: begin
                    if (SUPPORT_JAL) begin
                        d_regwrite = 1'b1;
                        d_jump     = 1'b1;
                        d_rd       = id_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt_nz = (cnt != 2'd0);
    assign haz    = ex_memread && (ex_rd != '0) &&
                    (((ex_rd == id_rs1) && use_rs1) || ((ex_rd == id_rs2) && use_rs2));
    assign flush     = mem_take;
    assign stall     = (haz || cnt_nz) && !mem_take;
    assign id_bubble = stall || flush;

    // A hazard seen while the counter is still running is not reloaded;
    // it is re-detected once the counter drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
        end else if (mem_take) begin
            cnt <= 2'd0;
        end else if (haz && !cnt_nz) begin
            cnt <= CNT_LOAD;
        end else if (cnt_nz) begin
            cnt <= cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ALUSrc   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_rd       <= '0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_jump     <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
        end else if (id_bubble) begin
            ex_ALUSrc   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_rd       <= '0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
            ex_jump     <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
        end else begin
            ex_ALUSrc   <= d_alusrc;
            ex_ALUOp    <= d_aluop;
            ex_rd       <= d_rd;
            ex_memread  <= d_memread;
            ex_memwrite <= d_memwrite;
            ex_branch   <= d_branch;
            ex_jump     <= d_jump;
            ex_regwrite <= d_regwrite;
            ex_memtoreg <= d_memtoreg;
        end
    end

    // The wrong-path instruction in EX is squashed; the taken branch itself moves on to WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_Branch   <= 1'b0;
            mem_Jump     <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
        end else if (flush) begin
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_Branch   <= 1'b0;
            mem_Jump     <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
        end else begin
            mem_MemRead  <= ex_memread;
            mem_MemWrite <= ex_memwrite;
            mem_Branch   <= ex_branch;
            mem_Jump     <= ex_jump;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            mem_memtoreg <= ex_memtoreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_RegWrite <= 1'b0;
            wb_MemtoReg <= 1'b0;
            wb_rd       <= '0;
        end else begin
            wb_RegWrite <= mem_regwrite;
            wb_MemtoReg <= mem_memtoreg;
            wb_rd       <= mem_rd;
        end
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Five-stage RISC-V control path: decodes the ID-stage opcode and carries the resulting control bits through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and generates a stall and bubble for a parametrised number of cycles.
- Squashes wrong-path control on a taken branch resolved in MEM.
- Sits beside the datapath pipeline registers and drives the per-stage mux, memory and write-back enables.

Parameters:
- RA_W, 5, register-address width for rd/rs1/rs2 compares.
- LOAD_STALL, 1, bubble cycles per load-use hazard; legal range 1..3.
- SUPPORT_JAL, 0, 1 = decode JAL (1101111) and drive the Jump bit.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- Opcode  in  7  ID-stage instruction[6:0]
- id_valid  in  1  ID-stage instruction is real (0 = treat as bubble)
- id_rs1, id_rs2, id_rd  in  RA_W  ID-stage register fields
- mem_take  in  1  branch/jump in MEM is taken (datapath qualifies mem_Branch with Zero)
- stall  out  1  hold PC and IF/ID
- flush  out  1  clear IF/ID
- ex_ALUSrc  out  1;  ex_ALUOp  out  2;  ex_rd  out  RA_W
- mem_MemRead, mem_MemWrite, mem_Branch, mem_Jump  out  1 each;  mem_rd  out  RA_W
- wb_RegWrite, wb_MemtoReg  out  1 each;  wb_rd  out  RA_W

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline control registers, rd fields and the stall counter go to 0, so every output is 0. Release is synchronous to the next clk edge.
- Decode (combinational, no latches). Fields are ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp.
  - R 0110011: 0,0,1,0,0,0,0,10
  - Load 0000011: 1,1,1,1,0,0,0,00
  - Store 0100011: 1,0,0,0,1,0,0,00
  - Branch 1100011: 0,0,0,0,0,1,0,01
  - I-arith 0010011: 1,0,1,0,0,0,0,11
  - JAL 1101111 (only when SUPPORT_JAL=1): 0,0,1,0,0,0,1,00
  - Any other opcode, or id_valid=0: all zero (bubble).
- Register-use flags:
  - rs1 used by R, load, store, branch, I-arith.
  - rs2 used by R, store, branch.
  - Neither is used by JAL.
- Pipeline timing: each edge shifts ID→EX→MEM→WB; per-stage latency is 1 cycle. The rd field travels with its controls.
- Hazard detect (combinational): haz = ex_MemRead & (ex_rd≠0) & ((ex_rd==id_rs1 & use_rs1) | (ex_rd==id_rs2 & use_rs2)).
- Stall counter cnt (2 bits):
  - On haz with cnt=0 and no flush: cnt ← LOAD_STALL−1.
  - Otherwise, if cnt≠0: cnt ← cnt−1.
  - stall = (haz | cnt≠0) & ~mem_take.
- While stall=1: ID/EX loads a bubble (all zero, rd=0). Downstream stages still advance. The ID inputs are held by the datapath and re-evaluated every cycle.
- Flush (mem_take=1, combinational):
  - flush=1 and stall forced to 0.
  - Next edge: ID/EX and EX/MEM load bubbles, and cnt ← 0.
  - MEM/WB captures the branch/jump normally, so JAL write-back survives.
- Priority: reset > flush > stall > normal advance.
- rd=0 never triggers a stall. A store's rs2 matching a load's rd does stall (no MEM-to-MEM forwarding assumed).
- Back-to-back hazards: a new haz while cnt≠0 does not reload the counter. Detection re-evaluates once cnt reaches 0.
- Reset asserted mid-stall or mid-flush clears everything immediately. No residual stall after release.

Test Plan:
- Reset: rst_n=0 while Opcode=0110011, id_valid=1 → all outputs 0 immediately, with no clk edge required. Release → ex_ALUOp=10 one edge after the first valid R-type.
- Decode sweep, id_valid=1, checked one cycle later at EX and the following cycle at MEM/WB:
  - 0000011 → ex_ALUSrc=1, mem_MemRead=1, wb_MemtoReg=1, wb_RegWrite=1.
  - 0100011 → mem_MemWrite=1, wb_RegWrite=0.
  - 0010011 → ex_ALUOp=11, mem_MemRead=0.
  - 1111111 → all zero.
- Load-use, LOAD_STALL=1: lw x5 then add x6,x5,x7 → stall=1 for exactly 1 cycle, ex_* all zero for that cycle, then add reaches EX. Same sequence with rd=x0 → no stall.
- Load-use, LOAD_STALL=3: same sequence → stall high for 3 consecutive cycles and 3 bubbles appear in EX. wb_RegWrite for the load asserts 2 cycles after it leaves EX.
- Taken branch: beq in MEM with mem_take=1 while a load-use hazard is present in ID/EX → flush=1, stall=0. Next edge ex_* and mem_* are zero and wb_* carries the beq (wb_RegWrite=0).
- JAL with SUPPORT_JAL=1: 1101111 → mem_Jump=1 and wb_RegWrite=1, and the flush on mem_take does not clear the JAL's wb_RegWrite. With SUPPORT_JAL=0, the same opcode yields all zero.
